// File: rtl/pad_link_tx_pkg.sv
// Shared pad-link definitions: TX FSM encoding, frame shape and payload
// packing, used by both the transmitter and the matching receiver.
package pad_link_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int   FRAME_BITS = 11;
  localparam int   DATA_BITS  = 8;
  localparam logic MARKER_BIT = 1'b1;

  function automatic logic [7:0] pad_byte(
    input logic [2:0] seq,
    input logic [3:0] btn
  );
    return {MARKER_BIT, seq, btn};
  endfunction

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/pad_debounce.sv
// One button bit: two-flop synchronizer followed by a hold-time debouncer.
// chg_o pulses for one cycle together with each stable_o update.
module pad_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic chg_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          s1_q;
  logic          s2_q;
  logic          stb_q;
  logic          chg_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      stb_q <= 1'b0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      chg_q <= 1'b0;
      if (s2_q == stb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        stb_q <= s2_q;
        chg_q <= 1'b1;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = stb_q;
  assign chg_o    = chg_q;

endmodule

// File: rtl/pad_link_tx.sv
// Gamepad link transmitter: debounced buttons are sent as 11-bit UART
// frames on every change and periodically as a keepalive.
module pad_link_tx
  import pad_link_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT     = 217,
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int KEEPALIVE_CYCLES = 2500000
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic [3:0] i_BTN,
  output logic       o_TX,
  output logic       o_BUSY,
  output logic [3:0] o_BTN_STABLE
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int KW = $clog2(KEEPALIVE_CYCLES + 1);

  logic [3:0]    stb;
  logic [3:0]    chg;
  logic          ka_hit;
  logic          req;
  logic [7:0]    data_d;

  tx_state_e     state_q;
  logic          tx_q;
  logic          busy_q;
  logic          pend_q;
  logic          par_q;
  logic [7:0]    sh_q;
  logic [2:0]    seq_q;
  logic [2:0]    nbit_q;
  logic [BW-1:0] bcnt_q;
  logic [KW-1:0] ka_q;
  logic          bit_end;

  for (genvar g = 0; g < 4; g++) begin : g_db
    pad_debounce #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (i_CLK),
      .rst_ni  (i_RST_N),
      .btn_i   (i_BTN[g]),
      .stable_o(stb[g]),
      .chg_o   (chg[g])
    );
  end

  assign ka_hit  = (ka_q == KW'(KEEPALIVE_CYCLES - 1));
  assign req     = (|chg) | ka_hit;
  assign data_d  = pad_byte(seq_q, stb);
  assign bit_end = (bcnt_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      par_q   <= 1'b0;
      sh_q    <= '0;
      seq_q   <= '0;
      nbit_q  <= '0;
      bcnt_q  <= '0;
      ka_q    <= '0;
    end else if (state_q == IDLE) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      if (req || pend_q) begin
        state_q <= START;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
        pend_q  <= 1'b0;
        sh_q    <= data_d;
        par_q   <= even_par(data_d);
        nbit_q  <= '0;
        bcnt_q  <= '0;
        ka_q    <= '0;
      end else begin
        ka_q <= ka_q + KW'(1);
      end
    end else begin
      ka_q <= '0;
      if (req) pend_q <= 1'b1;
      bcnt_q <= bit_end ? '0 : bcnt_q + BW'(1);
      if (bit_end) begin
        unique case (state_q)
          START: begin
            state_q <= DATA;
            tx_q    <= sh_q[0];
          end
          DATA: begin
            if (nbit_q == 3'(DATA_BITS - 1)) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              nbit_q <= nbit_q + 3'd1;
              sh_q   <= sh_q >> 1;
              tx_q   <= sh_q[1];
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            seq_q   <= seq_q + 3'd1;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_TX         = tx_q;
  assign o_BUSY       = busy_q;
  assign o_BTN_STABLE = stb;

endmodule

// File: tb/tb_pad_link_tx.sv
// Bench for pad_link_tx: a line monitor decodes frames into a queue that
// each scenario task checks against the frames it expects.
module tb_pad_link_tx;

  localparam int CPB  = 4;
  localparam int DEB  = 8;
  localparam int KA   = 200;
  localparam int FLEN = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0;
  logic       tx;
  logic       busy;
  logic [3:0] stb;

  always #5 clk = ~clk;

  pad_link_tx #(
    .CLKS_PER_BIT    (CPB),
    .DEBOUNCE_CYCLES (DEB),
    .KEEPALIVE_CYCLES(KA)
  ) dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .i_BTN       (btn),
    .o_TX        (tx),
    .o_BUSY      (busy),
    .o_BTN_STABLE(stb)
  );

  typedef struct {
    logic [10:0] bits;
    int          len;
    int          start;
  } rec_t;

  rec_t       rxq[$];
  logic [7:0] expq[$];
  int         nvec = 0;
  int         nerr = 0;
  int         cyc_n = 0;
  bit         mon_act = 0;
  int         mon_fc = 0;
  rec_t       cur;

  initial forever begin
    @(negedge clk);
    cyc_n++;
    if (!rst_n) begin
      mon_act = 0;
    end else if (busy) begin
      if (!mon_act) begin
        mon_act   = 1;
        mon_fc    = 0;
        cur.bits  = '1;
        cur.start = cyc_n;
      end
      if ((mon_fc % CPB) == CPB / 2 && (mon_fc / CPB) < 11)
        cur.bits[mon_fc / CPB] = tx;
      mon_fc++;
    end else if (mon_act) begin
      mon_act = 0;
      cur.len = mon_fc;
      rxq.push_back(cur);
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn   = 4'b0;
    cyc(3);
    rxq.delete();
    expq.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int bound);
    int k;
    k = 0;
    while (rxq.size() < n && k < bound) begin
      cyc(1);
      k++;
    end
  endtask

  task automatic wait_busy(input int bound, output bit ok);
    int k;
    k = 0;
    while (busy !== 1'b1 && k < bound) begin
      cyc(1);
      k++;
    end
    ok = (busy === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 4'b0;
    cyc(2);
    nvec++;
    if (tx !== 1'b1) begin
      nerr++; $display("FAIL reset_tx got %b want 1", tx);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL reset_busy got %b want 0", busy);
    end
    nvec++;
    if (stb !== 4'b0) begin
      nerr++; $display("FAIL reset_stable got %b want 0000", stb);
    end
    do_reset();
    cyc(150);
    nvec++;
    if (rxq.size() != 0) begin
      nerr++; $display("FAIL reset_quiet frames got %0d want 0", rxq.size());
    end
  endtask

  task automatic test_single_press();
    rec_t       r;
    logic [7:0] e;
    int         prev;
    do_reset();
    btn = 4'b0001;
    expq.push_back(8'h81);
    cyc(15);
    nvec++;
    if (stb !== 4'b0001) begin
      nerr++; $display("FAIL press_stable got %b want 0001", stb);
    end
    cyc(5);
    btn = 4'b0000;
    expq.push_back(8'h90);
    wait_rx(2, 300);
    nvec++;
    if (rxq.size() != 2) begin
      nerr++; $display("FAIL press_count got %0d want 2", rxq.size());
    end
    prev = -1;
    while (rxq.size() > 0 && expq.size() > 0) begin
      r = rxq.pop_front();
      e = expq.pop_front();
      nvec++;
      if (r.bits !== frame_of(e)) begin
        nerr++; $display("FAIL press_frame got %b want %b", r.bits, frame_of(e));
      end
      nvec++;
      if (r.len != FLEN) begin
        nerr++; $display("FAIL press_busy_len got %0d want %0d", r.len, FLEN);
      end
      if (prev >= 0) begin
        nvec++;
        if (r.start - prev != FLEN + 1) begin
          nerr++; $display("FAIL press_gap got %0d want %0d", r.start - prev, FLEN + 1);
        end
      end
      prev = r.start;
    end
  endtask

  task automatic test_glitch();
    bit seen;
    do_reset();
    cyc(5);
    btn = 4'b0100;
    cyc(5);
    btn = 4'b0000;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (stb !== 4'b0) seen = 1;
    end
    nvec++;
    if (seen) begin
      nerr++; $display("FAIL glitch_stable got changed want 0000");
    end
    cyc(80);
    nvec++;
    if (rxq.size() != 0) begin
      nerr++; $display("FAIL glitch_frames got %0d want 0", rxq.size());
    end
  endtask

  task automatic test_change_during_frame();
    rec_t       r;
    logic [7:0] e;
    int         prev;
    bit         ok;
    do_reset();
    btn = 4'b0001;
    expq.push_back(8'h81);
    wait_busy(100, ok);
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL chg_start got busy=%b want 1", busy);
    end
    cyc(16);
    btn = 4'b0011;
    cyc(12);
    btn = 4'b0001;
    expq.push_back(8'h91);
    cyc(4);
    nvec++;
    if (stb !== 4'b0011) begin
      nerr++; $display("FAIL chg_stable got %b want 0011", stb);
    end
    wait_rx(2, 200);
    cyc(60);
    nvec++;
    if (rxq.size() != 2) begin
      nerr++; $display("FAIL chg_count got %0d want 2", rxq.size());
    end
    prev = -1;
    while (rxq.size() > 0 && expq.size() > 0) begin
      r = rxq.pop_front();
      e = expq.pop_front();
      nvec++;
      if (r.bits !== frame_of(e)) begin
        nerr++; $display("FAIL chg_frame got %b want %b", r.bits, frame_of(e));
      end
      if (prev >= 0) begin
        nvec++;
        if (r.start - prev != FLEN + 1) begin
          nerr++; $display("FAIL chg_gap got %0d want %0d", r.start - prev, FLEN + 1);
        end
      end
      prev = r.start;
    end
  endtask

  task automatic test_keepalive_wrap();
    rec_t       r;
    logic [7:0] e;
    logic [7:0] v;
    int         prev;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      v = 8'h80;
      v[6:4] = 3'(i % 8);
      expq.push_back(v);
    end
    wait_rx(9, 9 * (KA + FLEN) + 400);
    nvec++;
    if (rxq.size() != 9) begin
      nerr++; $display("FAIL ka_count got %0d want 9", rxq.size());
    end
    prev = -1;
    while (rxq.size() > 0 && expq.size() > 0) begin
      r = rxq.pop_front();
      e = expq.pop_front();
      nvec++;
      if (r.bits !== frame_of(e)) begin
        nerr++; $display("FAIL ka_frame got %b want %b", r.bits, frame_of(e));
      end
      if (prev >= 0) begin
        nvec++;
        if (r.start - prev != KA + FLEN) begin
          nerr++; $display("FAIL ka_period got %0d want %0d", r.start - prev, KA + FLEN);
        end
      end
      prev = r.start;
    end
  endtask

  task automatic test_reset_mid_frame();
    rec_t       r;
    logic [7:0] e;
    bit         ok;
    do_reset();
    btn = 4'b0001;
    wait_busy(100, ok);
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL rstmid_start got busy=%b want 1", busy);
    end
    cyc(CPB + 5 * CPB + 1);
    rst_n = 1'b0;
    #1;
    nvec++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL rstmid_async got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    cyc(2);
    rxq.delete();
    rst_n = 1'b1;
    expq.push_back(8'h81);
    wait_rx(1, 150);
    nvec++;
    if (rxq.size() != 1) begin
      nerr++; $display("FAIL rstmid_count got %0d want 1", rxq.size());
    end
    while (rxq.size() > 0 && expq.size() > 0) begin
      r = rxq.pop_front();
      e = expq.pop_front();
      nvec++;
      if (r.bits !== frame_of(e)) begin
        nerr++; $display("FAIL rstmid_frame got %b want %b", r.bits, frame_of(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_change_during_frame();
    test_keepalive_wrap();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
